regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_mp_onehot_decoder.sv | 15 +
 rtl/regfile_mp.sv | 79 +++++++
 tb/tb_regfile_mp.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and index type for the multi-port register file
package regfile_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_AW    = $clog2(DEF_DEPTH);
   typedef logic [DEF_AW-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_mp_onehot_decoder.sv
// onehot_decoder: enabled index-to-one-hot strobe generator; indices >= N decode to all zeros
module onehot_decoder #(
   parameter int N  = 8,
   parameter int AW = 3
) (
   input  logic          en_i,
   input  logic [AW-1:0] idx_i,
   output logic [N-1:0]  onehot_o
);
   // One strobe per register; out-of-range indices match no bit
   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < N; i++) onehot_o[i] = en_i && (idx_i == AW'(i));
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: two-read, one-write register file with per-register busy (reservation) bits
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write,
   input  logic [AW-1:0]    writenum,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AW-1:0]    readnum_a,
   input  logic [AW-1:0]    readnum_b,
   output logic [WIDTH-1:0] data_out_a,
   output logic [WIDTH-1:0] data_out_b,
   output logic             busy_a,
   output logic             busy_b,
   input  logic             reserve,
   input  logic [AW-1:0]    reservenum,
   output logic             reserve_ok
);
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic [DEPTH-1:0] we_oh, rs_oh;
   logic             wr_hit, rs_busy;

   onehot_decoder #(.N(DEPTH), .AW(AW)) u_wdec (.en_i(write), .idx_i(writenum), .onehot_o(we_oh));
   onehot_decoder #(.N(DEPTH), .AW(AW)) u_rdec (.en_i(reserve), .idx_i(reservenum), .onehot_o(rs_oh));

   assign wr_hit = |we_oh;

   // Read muxes with optional write forwarding; unmatched indices read as zero and not busy
   always_comb begin
      data_out_a = '0;
      data_out_b = '0;
      busy_a     = 1'b0;
      busy_b     = 1'b0;
      rs_busy    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (readnum_a == AW'(i)) begin
            data_out_a = regs_q[i];
            busy_a     = busy_q[i];
         end
         if (readnum_b == AW'(i)) begin
            data_out_b = regs_q[i];
            busy_b     = busy_q[i];
         end
         if (reservenum == AW'(i)) rs_busy = busy_q[i];
      end
      if (BYPASS != 0 && wr_hit && readnum_a == writenum) begin
         data_out_a = data_in;
         busy_a     = 1'b0;
      end
      if (BYPASS != 0 && wr_hit && readnum_b == writenum) begin
         data_out_b = data_in;
         busy_b     = 1'b0;
      end
   end

   // Reservation accepted if target is free, or released by a same-cycle write; reserve wins over the write's clear
   always_comb begin
      reserve_ok = (|rs_oh) && (!rs_busy || (wr_hit && writenum == reservenum));
      busy_d     = (rs_oh & {DEPTH{reserve_ok}}) | (busy_q & ~we_oh);
   end

   // State update: reset dominates write and reserve
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
         for (int i = 0; i < DEPTH; i++) if (we_oh[i]) regs_q[i] <= data_in;
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for default, no-bypass and DEPTH=6 builds
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        reset, write, reserve;
   logic [2:0]  writenum, readnum_a, readnum_b, reservenum;
   logic [15:0] data_in;
   logic [15:0] da [3], db [3];
   logic        ba [3], bb [3], rok [3];

   typedef struct {
      int          id;
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic        ba;
      logic        bb;
      logic        rok;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u_byp (
      .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(da[0]), .data_out_b(db[0]),
      .busy_a(ba[0]), .busy_b(bb[0]), .reserve(reserve), .reservenum(reservenum), .reserve_ok(rok[0]));

   regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u_nob (
      .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(da[1]), .data_out_b(db[1]),
      .busy_a(ba[1]), .busy_b(bb[1]), .reserve(reserve), .reservenum(reservenum), .reserve_ok(rok[1]));

   regfile_mp #(.WIDTH(16), .DEPTH(6), .BYPASS(1)) u_d6 (
      .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(da[2]), .data_out_b(db[2]),
      .busy_a(ba[2]), .busy_b(bb[2]), .reserve(reserve), .reservenum(reservenum), .reserve_ok(rok[2]));

   task automatic drive(input logic rst, input logic w, input logic [2:0] wn, input logic [15:0] din,
                        input logic [2:0] ra, input logic [2:0] rb, input logic rs, input logic [2:0] rsn);
      reset = rst; write = w; writenum = wn; data_in = din;
      readnum_a = ra; readnum_b = rb; reserve = rs; reservenum = rsn;
   endtask

   task automatic expect_out(input int id, input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic xba, input logic xbb, input logic xrok);
      exp_t e;
      e.id = id; e.name = name; e.a = a; e.b = b; e.ba = xba; e.bb = xbb; e.rok = xrok;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every expectation pushed for the current cycle is checked mid-cycle
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if ({da[e.id], db[e.id], ba[e.id], bb[e.id], rok[e.id]} !== {e.a, e.b, e.ba, e.bb, e.rok}) begin
            errors++;
            $display("FAIL %s dut%0d: got a=%h b=%h ba=%b bb=%b rok=%b, want a=%h b=%h ba=%b bb=%b rok=%b",
                     e.name, e.id, da[e.id], db[e.id], ba[e.id], bb[e.id], rok[e.id],
                     e.a, e.b, e.ba, e.bb, e.rok);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      // cleared state on all indices, both ports
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, 0, 3'(i), 3'(7 - i), 0, 0);
         for (int d = 0; d < 3; d++) expect_out(d, "reset_read", 16'h0, 16'h0, 0, 0, 0);
         tick();
      end
      // write R3 then read on both ports
      drive(0, 1, 3, 16'hBEEF, 0, 0, 0, 0);
      expect_out(0, "wr3_cycle", 16'h0, 16'h0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 3, 3, 0, 0);
      for (int d = 0; d < 3; d++) expect_out(d, "rd3", 16'hBEEF, 16'hBEEF, 0, 0, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         if (i == 3) continue;
         drive(0, 0, 0, 0, 3'(i), 3'(i), 0, 0);
         expect_out(0, "others_zero", 16'h0, 16'h0, 0, 0, 0);
         tick();
      end
      // same-cycle write/read of R5: forwarded vs old value
      drive(0, 1, 5, 16'h1234, 5, 3, 0, 0);
      expect_out(0, "bypass_r5", 16'h1234, 16'hBEEF, 0, 0, 0);
      expect_out(1, "nobypass_r5", 16'h0, 16'hBEEF, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 5, 5, 0, 0);
      expect_out(1, "nobypass_r5_next", 16'h1234, 16'h1234, 0, 0, 0);
      tick();
      // reserve R2, re-reserve refused, write clears busy
      drive(0, 0, 0, 0, 2, 0, 1, 2);
      expect_out(0, "rsv2", 16'h0, 16'h0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 2, 0, 1, 2);
      expect_out(0, "rsv2_again", 16'h0, 16'h0, 1, 0, 0);
      expect_out(1, "rsv2_again_nb", 16'h0, 16'h0, 1, 0, 0);
      tick();
      drive(0, 1, 2, 16'h00AA, 2, 0, 0, 0);
      expect_out(0, "wr2_bypass", 16'h00AA, 16'h0, 0, 0, 0);
      expect_out(1, "wr2_nobypass", 16'h0, 16'h0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 2, 2, 0, 0);
      expect_out(0, "rd2_after", 16'h00AA, 16'h00AA, 0, 0, 0);
      expect_out(1, "rd2_after_nb", 16'h00AA, 16'h00AA, 0, 0, 0);
      tick();
      // write and reserve R4 together: data lands, busy set
      drive(0, 1, 4, 16'h5555, 4, 0, 1, 4);
      expect_out(0, "wr_rsv4", 16'h5555, 16'h0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 4, 4, 0, 0);
      expect_out(0, "rd4_busy", 16'h5555, 16'h5555, 1, 1, 0);
      expect_out(1, "rd4_busy_nb", 16'h5555, 16'h5555, 1, 1, 0);
      tick();
      // R4 busy: reserve accepted because a same-cycle write releases it
      drive(0, 1, 4, 16'h0777, 4, 0, 1, 4);
      expect_out(0, "rsv4_release", 16'h0777, 16'h0, 0, 0, 1);
      expect_out(1, "rsv4_release_nb", 16'h5555, 16'h0, 1, 0, 1);
      tick();
      drive(0, 0, 0, 0, 4, 0, 1, 4);
      expect_out(0, "rd4_rebusy", 16'h0777, 16'h0, 1, 0, 0);
      tick();
      // write and reserve to different registers
      drive(0, 1, 2, 16'h0001, 0, 0, 1, 7);
      expect_out(0, "wr2_rsv7", 16'h0, 16'h0, 0, 0, 1);
      expect_out(2, "d6_rsv7", 16'h0, 16'h0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 2, 7, 0, 0);
      expect_out(0, "rd2_rd7", 16'h0001, 16'h0, 0, 1, 0);
      expect_out(2, "d6_rd2_rd7", 16'h0001, 16'h0, 0, 0, 0);
      tick();
      // reset beats write and reserve in the same cycle
      drive(1, 1, 1, 16'hFFFF, 1, 6, 1, 6);
      tick();
      drive(0, 0, 0, 0, 1, 6, 0, 0);
      expect_out(0, "post_reset_16", 16'h0, 16'h0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 3, 4, 1, 6);
      expect_out(0, "post_reset_34", 16'h0, 16'h0, 0, 0, 1);
      expect_out(2, "d6_rsv6", 16'h0, 16'h0, 0, 0, 0);
      tick();
      // DEPTH=6: out-of-range write ignored, not forwarded
      drive(0, 1, 7, 16'h7777, 7, 7, 0, 0);
      expect_out(0, "wr7_bypass", 16'h7777, 16'h7777, 0, 0, 0);
      expect_out(2, "d6_wr7_cycle", 16'h0, 16'h0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 7, 6, 0, 0);
      expect_out(0, "rd7", 16'h7777, 16'h0, 0, 1, 0);
      expect_out(2, "d6_rd7", 16'h0, 16'h0, 0, 0, 0);
      tick();
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
